// File: rtl/dmx_channel_scheduler.sv
// DMX channel table shared by the serial writer (reads), tracker A and host B (round-robin writes).
// Define DMX_DOUBLE_BUFFER_EN to stage writes in a shadow table that is committed on frame_sync.
module dmx_channel_scheduler #(
  parameter int NUM_CH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] req_addr,
  input  logic       req_pulse,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       a_we,
  input  logic [8:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_we,
  input  logic [8:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ack,
  input  logic       frame_sync,
  output logic       commit_busy
);
  localparam int IDXW = $clog2(NUM_CH + 1);

  logic [7:0]      r_live [1:NUM_CH];
  logic            r_rrPtr;
  logic            w_inCommit;
  logic            w_rdInRange;
  logic            w_aElig;
  logic            w_bElig;
  logic            w_grantA;
  logic            w_grantB;
  logic            w_wrInRange;
  logic            w_wrEn;
  logic [8:0]      w_wrAddr;
  logic [7:0]      w_wrData;
  logic [IDXW-1:0] w_rdIdx;
  logic [IDXW-1:0] w_wrIdx;

  assign w_rdInRange = (req_addr != 9'd0) && (req_addr <= 9'(NUM_CH));
  assign w_rdIdx     = req_addr[IDXW-1:0];

  // A requester whose ack is high this cycle is already served; this stops a double write.
  assign w_aElig  = a_we && !a_ack && !req_pulse && !w_inCommit;
  assign w_bElig  = b_we && !b_ack && !req_pulse && !w_inCommit;
  assign w_grantA = w_aElig && (!w_bElig || !r_rrPtr);
  assign w_grantB = w_bElig && (!w_aElig || r_rrPtr);

  assign w_wrAddr    = w_grantB ? b_addr : a_addr;
  assign w_wrData    = w_grantB ? b_data : a_data;
  assign w_wrInRange = (w_wrAddr != 9'd0) && (w_wrAddr <= 9'(NUM_CH));
  assign w_wrIdx     = w_wrAddr[IDXW-1:0];
  assign w_wrEn      = (w_grantA || w_grantB) && w_wrInRange;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data  <= 8'd0;
      resp_valid <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      r_rrPtr    <= 1'b0;
    end else begin
      resp_valid <= req_pulse;
      if (req_pulse) begin
        resp_data <= w_rdInRange ? r_live[w_rdIdx] : 8'd0;
      end
      a_ack <= w_grantA;
      b_ack <= w_grantB;
      if (w_aElig && w_bElig) begin
        r_rrPtr <= ~r_rrPtr;
      end
    end
  end

`ifdef DMX_DOUBLE_BUFFER_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  logic [7:0]      r_shadow [1:NUM_CH];
  logic [0:0]      r_state;
  logic            r_commitPending;
  logic [IDXW-1:0] r_cIdx;

  assign w_inCommit  = (r_state == ST_COMMIT);
  assign commit_busy = w_inCommit;

  // A read steals the table port, so the copy step holds its index for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        r_live[i]   <= 8'd0;
        r_shadow[i] <= 8'd0;
      end
      r_state         <= ST_IDLE;
      r_commitPending <= 1'b0;
      r_cIdx          <= IDXW'(1);
    end else begin
      if (w_wrEn) begin
        r_shadow[w_wrIdx] <= w_wrData;
      end
      if (frame_sync) begin
        r_commitPending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_commitPending) begin
            r_state <= ST_COMMIT;
            r_cIdx  <= IDXW'(1);
          end
        end
        default: begin
          if (!req_pulse) begin
            r_live[r_cIdx] <= r_shadow[r_cIdx];
            if (r_cIdx == IDXW'(NUM_CH)) begin
              r_state         <= ST_IDLE;
              r_commitPending <= 1'b0;
            end else begin
              r_cIdx <= r_cIdx + IDXW'(1);
            end
          end
        end
      endcase
    end
  end
`else
  logic w_unusedFrameSync;

  assign w_unusedFrameSync = frame_sync;
  assign w_inCommit        = 1'b0;
  assign commit_busy       = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        r_live[i] <= 8'd0;
      end
    end else if (w_wrEn) begin
      r_live[w_wrIdx] <= w_wrData;
    end
  end
`endif

endmodule

// File: tb/tb_dmx_channel_scheduler.sv
// Scoreboard bench for dmx_channel_scheduler: a table-level model predicts read data and ack order.
`timescale 1ns/1ps
module tb_dmx_channel_scheduler;
  localparam int NUM_CH    = 16;
  localparam int MODE_IDLE = 0;
  localparam int MODE_HOLD = 1;
  localparam int MODE_RAND = 2;

  typedef struct {
    int cyc;
    int val;
  } expT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] req_addr = '0;
  logic       req_pulse = 1'b0;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       a_we = 1'b0;
  logic [8:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       a_ack;
  logic       b_we = 1'b0;
  logic [8:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ack;
  logic       frame_sync = 1'b0;
  logic       commit_busy;

  dmx_channel_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_pulse(req_pulse),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .frame_sync(frame_sync), .commit_busy(commit_busy)
  );

  always #5 clk = ~clk;

  int cycCnt = 0;
  always @(posedge clk) cycCnt++;

  int  nCompared = 0;
  int  nMismatch = 0;
  expT expRd[$];
  expT expAck[$];
  expT monE;

  // Reference state: what each table holds and who owes whom an ack
  int  liveM[1:NUM_CH];
  int  shadowM[1:NUM_CH];
  bit  mAckA, mAckB, mPend, mCommit;
  int  mRr, mIdx, lastWin;

  bit         aWe, bWe;
  logic [8:0] aAddr, bAddr;
  logic [7:0] aData, bData;
  int         aMode, bMode;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cycCnt);
    end
  endtask

  function automatic bit inRange(input logic [8:0] a);
    return (a >= 9'd1) && (a <= 9'(NUM_CH));
  endfunction

  function automatic logic [8:0] randAddr();
    return 9'($urandom_range(0, NUM_CH + 2));
  endfunction

  task automatic modelReset();
    for (int i = 1; i <= NUM_CH; i++) begin
      liveM[i]   = 0;
      shadowM[i] = 0;
    end
    mAckA = 0; mAckB = 0; mPend = 0; mCommit = 0; mRr = 0; mIdx = 1; lastWin = -1;
  endtask

  task automatic modelStep(input bit rd, input logic [8:0] ra, input bit fs);
    bit         aE, bE, oldPend;
    logic [8:0] wa;
    if (rd) expRd.push_back('{cycCnt + 1, inRange(ra) ? liveM[int'(ra)] : 0});
    aE = aWe && !mAckA && !rd && !mCommit;
    bE = bWe && !mAckB && !rd && !mCommit;
    lastWin = -1;
    if (aE && bE) begin
      lastWin = mRr;
      mRr = 1 - mRr;
    end else if (aE) lastWin = 0;
    else if (bE) lastWin = 1;
    mAckA = (lastWin == 0);
    mAckB = (lastWin == 1);
    if (lastWin >= 0) begin
      expAck.push_back('{cycCnt + 1, lastWin});
      wa = (lastWin == 1) ? bAddr : aAddr;
      if (inRange(wa)) begin
`ifdef DMX_DOUBLE_BUFFER_EN
        shadowM[int'(wa)] = (lastWin == 1) ? int'(bData) : int'(aData);
`else
        liveM[int'(wa)] = (lastWin == 1) ? int'(bData) : int'(aData);
`endif
      end
    end
`ifdef DMX_DOUBLE_BUFFER_EN
    oldPend = mPend;
    if (fs) mPend = 1;
    if (mCommit) begin
      if (!rd) begin
        liveM[mIdx] = shadowM[mIdx];
        if (mIdx == NUM_CH) begin
          mCommit = 0;
          mPend   = 0;
        end else mIdx++;
      end
    end else if (oldPend) begin
      mCommit = 1;
      mIdx    = 1;
    end
`else
    oldPend = fs;
`endif
  endtask

  task automatic updateRequesters();
    if (lastWin == 0) begin
      if (aMode == MODE_RAND && $urandom_range(0, 1) == 1) begin
        aAddr = randAddr(); aData = 8'($urandom_range(0, 255));
      end else if (aMode != MODE_HOLD) aWe = 0;
    end else if (aMode == MODE_RAND && !aWe && $urandom_range(0, 3) == 0) begin
      aWe = 1; aAddr = randAddr(); aData = 8'($urandom_range(0, 255));
    end
    if (lastWin == 1) begin
      if (bMode == MODE_RAND && $urandom_range(0, 1) == 1) begin
        bAddr = randAddr(); bData = 8'($urandom_range(0, 255));
      end else if (bMode != MODE_HOLD) bWe = 0;
    end else if (bMode == MODE_RAND && !bWe && $urandom_range(0, 3) == 0) begin
      bWe = 1; bAddr = randAddr(); bData = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic applyStimulus(input bit rd, input logic [8:0] ra, input bit fs);
    req_pulse = rd; req_addr = ra; frame_sync = fs;
    a_we = aWe; a_addr = aAddr; a_data = aData;
    b_we = bWe; b_addr = bAddr; b_data = bData;
    modelStep(rd, ra, fs);
    @(posedge clk);
    #1;
    checkOutput("commit_busy", int'(commit_busy), int'(mCommit));
    req_pulse = 1'b0; frame_sync = 1'b0;
    updateRequesters();
  endtask

  task automatic doReset();
    reset = 1'b1; req_pulse = 1'b0; frame_sync = 1'b0; a_we = 1'b0; b_we = 1'b0;
    aWe = 0; bWe = 0; aMode = MODE_IDLE; bMode = MODE_IDLE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOutput("rst_resp_valid", int'(resp_valid), 0);
    checkOutput("rst_resp_data", int'(resp_data), 0);
    checkOutput("rst_a_ack", int'(a_ack), 0);
    checkOutput("rst_b_ack", int'(b_ack), 0);
    checkOutput("rst_commit_busy", int'(commit_busy), 0);
  endtask

  task automatic readAll();
    for (int ch = 1; ch <= NUM_CH; ch++) applyStimulus(1'b1, 9'(ch), 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0);
  endtask

  // Monitor: every DUT strobe must match the oldest expectation for this exact cycle
  always @(negedge clk) begin
    while (expRd.size() > 0 && expRd[0].cyc < cycCnt) begin
      nCompared++; nMismatch++;
      $display("[TB] FAIL resp_missing: got no resp_valid, want data %0d at cycle %0d", expRd[0].val, expRd[0].cyc);
      void'(expRd.pop_front());
    end
    while (expAck.size() > 0 && expAck[0].cyc < cycCnt) begin
      nCompared++; nMismatch++;
      $display("[TB] FAIL ack_missing: got no ack, want ack from %0d at cycle %0d", expAck[0].val, expAck[0].cyc);
      void'(expAck.pop_front());
    end
    if (resp_valid) begin
      if (expRd.size() > 0 && expRd[0].cyc == cycCnt) begin
        monE = expRd.pop_front();
        checkOutput("resp_data", int'(resp_data), monE.val);
      end else begin
        nCompared++; nMismatch++;
        $display("[TB] FAIL resp_unexpected: got resp_valid=1 data %0d, want no response (cycle %0d)", resp_data, cycCnt);
      end
    end
    if (a_ack) begin
      if (expAck.size() > 0 && expAck[0].cyc == cycCnt) begin
        monE = expAck.pop_front();
        checkOutput("ack_who(A=0)", 0, monE.val);
      end else begin
        nCompared++; nMismatch++;
        $display("[TB] FAIL a_ack_unexpected: got a_ack=1, want 0 (cycle %0d)", cycCnt);
      end
    end
    if (b_ack) begin
      if (expAck.size() > 0 && expAck[0].cyc == cycCnt) begin
        monE = expAck.pop_front();
        checkOutput("ack_who(B=1)", 1, monE.val);
      end else begin
        nCompared++; nMismatch++;
        $display("[TB] FAIL b_ack_unexpected: got b_ack=1, want 0 (cycle %0d)", cycCnt);
      end
    end
  end

  initial begin
    aMode = MODE_IDLE; bMode = MODE_IDLE; aWe = 0; bWe = 0;
    aAddr = '0; bAddr = '0; aData = '0; bData = '0;
    modelReset();
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] empty table and out-of-range reads");
    applyStimulus(1'b1, 9'd3, 1'b0);
    applyStimulus(1'b1, 9'd0, 1'b0);
    applyStimulus(1'b1, 9'd17, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0);

    $display("[TB] single write from A");
    aWe = 1; aAddr = 9'd5; aData = 8'd254;
    applyStimulus(1'b0, 9'd0, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0);
    applyStimulus(1'b1, 9'd5, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(i % 3 == 0, 9'd5, i == 1);
    applyStimulus(1'b1, 9'd5, 1'b0);

    $display("[TB] contended writes to channel 4");
    aMode = MODE_HOLD; bMode = MODE_HOLD;
    aWe = 1; aAddr = 9'd4; aData = 8'd90;
    bWe = 1; bAddr = 9'd4; bData = 8'd160;
    for (int i = 0; i < 10; i++) applyStimulus(i == 4, 9'd4, 1'b0);
    aMode = MODE_IDLE; bMode = MODE_IDLE; aWe = 0; bWe = 0;
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, 9'd0, i == 0);
    applyStimulus(1'b1, 9'd4, 1'b0);

    $display("[TB] read coincident with write");
    aWe = 1; aAddr = 9'd7; aData = 8'd33;
    applyStimulus(1'b1, 9'd7, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0);
    applyStimulus(1'b1, 9'd7, 1'b0);

`ifdef DMX_DOUBLE_BUFFER_EN
    $display("[TB] commit with interleaved reads and a second frame_sync");
    for (int i = 0; i < 40; i++) applyStimulus(i % 3 == 1, 9'($urandom_range(1, NUM_CH)), i == 0 || i == 6);
    readAll();

    $display("[TB] reset in the middle of a commit");
    aWe = 1; aAddr = 9'd2; aData = 8'd77;
    applyStimulus(1'b0, 9'd0, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b1);
    for (int k = 0; k < 40 && !(mCommit && mIdx == 8); k++) applyStimulus(1'b0, 9'd0, 1'b0);
    doReset();
    readAll();
`endif

    $display("[TB] randomized traffic");
    aMode = MODE_RAND; bMode = MODE_RAND;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1300) begin
        doReset();
        aMode = MODE_RAND; bMode = MODE_RAND;
      end
      applyStimulus($urandom_range(0, 2) == 0, randAddr(), $urandom_range(0, 39) == 0);
    end

    aMode = MODE_IDLE; bMode = MODE_IDLE;
    for (int k = 0; k < 100 && (aWe || bWe); k++) applyStimulus(1'b0, 9'd0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 9'd0, i == 0);
    readAll();
    applyStimulus(1'b0, 9'd0, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0);
    checkOutput("rd_queue_left", expRd.size(), 0);
    checkOutput("ack_queue_left", expAck.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
